// File: rtl/pipelsu.sv
// MEM-stage load/store unit: sub-word loads with extension, read-modify-write
// sub-word stores, misalignment rejection and pipeline stall for multi-cycle ops.
module pipelsu #(
    parameter int RD_LAT = 2
) (
    input  logic        clock,
    input  logic        clrn,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        ldone,
    output logic [31:0] ldata,
    output logic        misalign,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;
    localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_RETIRE = 2'b10
    } state_t;

    state_t      state_r;
    logic [2:0]  cnt_r;
    logic [2:0]  op_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] merge_r;
    logic [31:0] ldata_r;
    logic        mis_s;
    logic        accept_s;

    function automatic logic is_load_f(input logic [2:0] o);
        return (o <= OP_LBU);
    endfunction

    function automatic logic misaligned_f(input logic [2:0] o, input logic [1:0] a);
        case (o)
            OP_LW, OP_SW:         return (a != 2'b00);
            OP_LH, OP_LHU, OP_SH: return a[0];
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] extract_f(input logic [2:0] o, input logic [1:0] a,
                                              input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (o)
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0000, h};
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h000000, b};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge_f(input logic [2:0] o, input logic [1:0] a,
                                            input logic [31:0] w, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (o)
            OP_SH:   r[{a[1], 4'b0000} +: 16] = d[15:0];
            OP_SB:   r[{a, 3'b000} +: 8] = d[7:0];
            default: r = w;
        endcase
        return r;
    endfunction

    assign mis_s    = misaligned_f(op, addr[1:0]);
    assign accept_s = req && !mis_s && (op != OP_SW);
    assign ldata    = ldata_r;

    // State machine, latency counter, latched operation and load result.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            op_r    <= 3'd0;
            addr_r  <= 32'h0;
            wdata_r <= 32'h0;
            merge_r <= 32'h0;
            ldata_r <= 32'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r    <= op;
                        addr_r  <= addr;
                        wdata_r <= wdata;
                        cnt_r   <= 3'd1;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == RD_LAT_C) begin
                        merge_r <= mem_dout;
                        if (is_load_f(op_r)) begin
                            ldata_r <= extract_f(op_r, addr_r[1:0], mem_dout);
                        end
                        state_r <= ST_RETIRE;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                ST_RETIRE: begin
                    cnt_r   <= 3'd0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    cnt_r   <= 3'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes and memory port; IDLE responds to the incoming request in the same cycle.
    always_comb begin
        stall    = 1'b0;
        ldone    = 1'b0;
        misalign = 1'b0;
        mem_we   = 1'b0;
        mem_din  = 32'h0;
        mem_addr = {addr_r[31:2], 2'b00};
        case (state_r)
            ST_IDLE: begin
                mem_addr = {addr[31:2], 2'b00};
                if (!req) begin
                    stall = 1'b0;
                end else if (mis_s) begin
                    misalign = 1'b1;
                end else if (op == OP_SW) begin
                    mem_we  = 1'b1;
                    mem_din = wdata;
                end else begin
                    stall = 1'b1;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
            end
            ST_RETIRE: begin
                if (is_load_f(op_r)) begin
                    ldone = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    mem_din = merge_f(op_r, addr_r[1:0], merge_r, wdata_r);
                end
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pipelsu.sv
// Directed bench for pipelsu: a RD_LAT=2 instance and a RD_LAT=1 instance, each
// attached to a small latency-matched memory model.
module tb_pipelsu;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    localparam logic [1:0] K_MULTI = 2'd0;
    localparam logic [1:0] K_SW    = 2'd1;
    localparam logic [1:0] K_MIS   = 2'd2;

    typedef struct packed {
        logic        sel;
        logic [1:0]  kind;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        clrn = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        stall_a, ldone_a, mis_a, we_a;
    logic        stall_b, ldone_b, mis_b, we_b;
    logic [31:0] ldata_a, maddr_a, din_a, dout_a;
    logic [31:0] ldata_b, maddr_b, din_b, dout_b;

    logic        pre_we = 1'b0;
    logic [31:0] pre_addr = 32'h0, pre_data = 32'h0;
    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic [31:0] pipe_a0, pipe_a1, pipe_b0;

    logic        cur = 1'b0;
    logic        o_stall, o_ldone, o_mis, o_we;
    logic [31:0] o_ldata, o_maddr, o_din;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] prev_ldata_a = 32'h0;
    logic [31:0] prev_ldata_b = 32'h0;
    vec_t vec [0:15];
    int   nv;

    always #5 clock = ~clock;

    pipelsu #(.RD_LAT(2)) u_dut_a (
        .clock(clock), .clrn(clrn), .req(req_a), .op(op), .addr(addr), .wdata(wdata),
        .stall(stall_a), .ldone(ldone_a), .ldata(ldata_a), .misalign(mis_a),
        .mem_we(we_a), .mem_addr(maddr_a), .mem_din(din_a), .mem_dout(dout_a)
    );

    pipelsu #(.RD_LAT(1)) u_dut_b (
        .clock(clock), .clrn(clrn), .req(req_b), .op(op), .addr(addr), .wdata(wdata),
        .stall(stall_b), .ldone(ldone_b), .ldata(ldata_b), .misalign(mis_b),
        .mem_we(we_b), .mem_addr(maddr_b), .mem_din(din_b), .mem_dout(dout_b)
    );

    // Memory models: word array with a read pipeline of RD_LAT registers.
    always @(posedge clock) begin
        if (pre_we) begin
            mem_a[pre_addr[7:2]] <= pre_data;
            mem_b[pre_addr[7:2]] <= pre_data;
        end else begin
            if (we_a) mem_a[maddr_a[7:2]] <= din_a;
            if (we_b) mem_b[maddr_b[7:2]] <= din_b;
        end
        pipe_a0 <= mem_a[maddr_a[7:2]];
        pipe_a1 <= pipe_a0;
        pipe_b0 <= mem_b[maddr_b[7:2]];
    end
    assign dout_a = pipe_a1;
    assign dout_b = pipe_b0;

    assign o_stall = cur ? stall_b : stall_a;
    assign o_ldone = cur ? ldone_b : ldone_a;
    assign o_mis   = cur ? mis_b   : mis_a;
    assign o_we    = cur ? we_b    : we_a;
    assign o_ldata = cur ? ldata_b : ldata_a;
    assign o_maddr = cur ? maddr_b : maddr_a;
    assign o_din   = cur ? din_b   : din_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clock); #1;
        pre_we = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        int          ns;
        logic        bad;
        logic [31:0] wa;
        logic [31:0] prev;
        cur = v.sel;
        op = v.op; addr = v.addr; wdata = v.wdata;
        req_a = !v.sel; req_b = v.sel;
        wa = {v.addr[31:2], 2'b00};
        prev = v.sel ? prev_ldata_b : prev_ldata_a;
        @(negedge clock);
        case (v.kind)
            K_MIS: begin
                chk("mis_pulse", {31'h0, o_mis}, 32'h1);
                chk("mis_stall", {29'h0, o_stall, o_we, o_ldone}, 32'h0);
                chk("mis_ldata_held", o_ldata, prev);
                @(posedge clock); #1;
                req_a = 1'b0; req_b = 1'b0;
                @(negedge clock);
                chk("mis_one_cycle", {31'h0, o_mis}, 32'h0);
            end
            K_SW: begin
                chk("sw_we", {29'h0, o_we, o_stall, o_ldone}, 32'h4);
                chk("sw_addr", o_maddr, wa);
                chk("sw_din", o_din, v.wdata);
                @(posedge clock); #1;
                req_a = 1'b0; req_b = 1'b0;
                @(negedge clock);
                chk("sw_one_cycle", {31'h0, o_we}, 32'h0);
            end
            default: begin
                ns = 0;
                bad = 1'b0;
                while (o_stall === 1'b1 && ns < 12) begin
                    ns++;
                    if (o_ldone !== 1'b0 || o_we !== 1'b0 || o_mis !== 1'b0 || o_maddr !== wa)
                        bad = 1'b1;
                    @(negedge clock);
                end
                chk("stall_len", 32'(ns), v.sel ? 32'd2 : 32'd3);
                chk("stall_strobes", {31'h0, bad}, 32'h0);
                if (v.op <= OP_LBU) begin
                    chk("ld_done", {30'h0, o_ldone, o_we}, 32'h2);
                    chk("ld_data", o_ldata, v.exp);
                    if (v.sel) prev_ldata_b = v.exp;
                    else prev_ldata_a = v.exp;
                end else begin
                    chk("st_we", {30'h0, o_we, o_ldone}, 32'h2);
                    chk("st_addr", o_maddr, wa);
                    chk("st_din", o_din, v.exp);
                end
                @(posedge clock); #1;
                req_a = 1'b0; req_b = 1'b0;
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        nv = 0;
        vec[nv] = '{1'b0, K_MULTI, OP_LW,  32'h10, 32'h0,        32'h8899AABB}; nv++;
        vec[nv] = '{1'b0, K_MULTI, OP_LB,  32'h13, 32'h0,        32'hFFFFFF88}; nv++;
        vec[nv] = '{1'b0, K_MULTI, OP_LBU, 32'h13, 32'h0,        32'h00000088}; nv++;
        vec[nv] = '{1'b0, K_MULTI, OP_LH,  32'h10, 32'h0,        32'hFFFFAABB}; nv++;
        vec[nv] = '{1'b0, K_MULTI, OP_LHU, 32'h12, 32'h0,        32'h00008899}; nv++;
        vec[nv] = '{1'b0, K_MULTI, OP_LBU, 32'h10, 32'h0,        32'h000000BB}; nv++;
        vec[nv] = '{1'b0, K_MIS,   OP_LH,  32'h13, 32'h0,        32'h0};        nv++;
        vec[nv] = '{1'b0, K_MULTI, OP_SB,  32'h11, 32'h5A,       32'h88995ABB}; nv++;
        vec[nv] = '{1'b0, K_MULTI, OP_SH,  32'h12, 32'h1234,     32'h1234AABB}; nv++;
        vec[nv] = '{1'b0, K_MULTI, OP_SB,  32'h10, 32'hFFFFFF77, 32'h8899AA77}; nv++;
        vec[nv] = '{1'b0, K_MULTI, OP_SH,  32'h10, 32'hCAFE5555, 32'h88995555}; nv++;
        vec[nv] = '{1'b0, K_SW,    OP_SW,  32'h20, 32'hDEADBEEF, 32'h0};        nv++;
        vec[nv] = '{1'b0, K_MIS,   OP_SW,  32'h16, 32'h11111111, 32'h0};        nv++;
        vec[nv] = '{1'b0, K_MIS,   OP_LW,  32'h12, 32'h0,        32'h0};        nv++;
        vec[nv] = '{1'b0, K_MIS,   OP_LHU, 32'h11, 32'h0,        32'h0};        nv++;

        #12;
        chk("rst_strobes", {28'h0, stall_a, ldone_a, mis_a, we_a}, 32'h0);
        chk("rst_din", din_a, 32'h0);
        chk("rst_ldata", ldata_a, 32'h0);
        @(negedge clock);
        clrn = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < nv; i++) begin
            preload(32'h10, 32'h8899AABB);
            run_op(vec[i]);
        end

        // Reset asserted while an SH is waiting on memory: nothing must be written.
        preload(32'h10, 32'h8899AABB);
        cur = 1'b0; op = OP_SH; addr = 32'h10; wdata = 32'h1234; req_a = 1'b1;
        @(posedge clock); #1;
        req_a = 1'b0;
        @(negedge clock);
        chk("wait_stall", {31'h0, stall_a}, 32'h1);
        #1;
        clrn = 1'b0;
        #1;
        chk("arst_strobes", {28'h0, stall_a, ldone_a, mis_a, we_a}, 32'h0);
        chk("arst_din", din_a, 32'h0);
        chk("arst_ldata", ldata_a, 32'h0);
        prev_ldata_a = 32'h0;
        @(posedge clock); @(posedge clock); @(negedge clock);
        clrn = 1'b1;
        @(posedge clock); @(posedge clock); #1;
        chk("arst_no_write", mem_a[4], 32'h8899AABB);
        run_op('{1'b0, K_MULTI, OP_LW, 32'h10, 32'h0, 32'h8899AABB});

        // RD_LAT=1 instance: LB then SB back-to-back, then read the merged word back.
        preload(32'h10, 32'h8899AABB);
        run_op('{1'b1, K_MULTI, OP_LB, 32'h13, 32'h0,  32'hFFFFFF88});
        run_op('{1'b1, K_MULTI, OP_SB, 32'h11, 32'h5A, 32'h88995ABB});
        run_op('{1'b1, K_MULTI, OP_LW, 32'h10, 32'h0,  32'h88995ABB});
        run_op('{1'b1, K_SW,    OP_SW, 32'h24, 32'h0BADF00D, 32'h0});
        run_op('{1'b1, K_MIS,   OP_SH, 32'h15, 32'h0,  32'h0});

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
